// File: rtl/sync_debounce_pkg.sv
// Shared constants and helpers for the sync_debounce input conditioner.
//   SYNC_MIN_DEPTH / SYNC_MAX_DEPTH : legal synchronizer depth range
//   SYNC_MAX_STABLE                 : largest legal STABLE_CYCLES
//   sync_cnt_width()                : debounce counter width, never below 1
//   sync_params_ok()                : range check used at elaboration
package sync_pkg;

    localparam int SYNC_MIN_DEPTH  = 2;
    localparam int SYNC_MAX_DEPTH  = 8;
    localparam int SYNC_MAX_STABLE = 65535;

    function automatic int sync_cnt_width(input int stable);
        int w;
        w = $clog2(stable);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit sync_params_ok(input int depth, input int stable);
        return (depth >= SYNC_MIN_DEPTH) && (depth <= SYNC_MAX_DEPTH) &&
               (stable >= 1) && (stable <= SYNC_MAX_STABLE);
    endfunction

endpackage

// File: rtl/sync_debounce_if.sv
// Signal bundle between raw pins and the debounced core-side view.
//   in      : raw asynchronous inputs (driven by master)
//   out     : debounced, synchronized levels
//   rise    : one-cycle pulse on out 0->1, per channel
//   fall    : one-cycle pulse on out 1->0, per channel
//   changed : registered OR of rise|fall across all channels
interface sync_debounce_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (output in, input out, rise, fall, changed);
    modport slave  (input in, output out, rise, fall, changed);
endinterface

// File: rtl/sync_debounce_channel.sv
// One channel: DEPTH-flop synchronizer, debounce counter and edge registers.
//   clock, reset_n : clock and asynchronous active-low reset
//   raw            : asynchronous input bit
//   level          : debounced level
//   rise, fall     : registered single-cycle edge pulses
// Edge registers exist only when SYNC_EDGE_DETECT_EN is defined; otherwise
// rise/fall are constant 0 and level timing is unchanged.
module sync_debounce_channel
    import sync_pkg::*;
#(
    parameter int   DEPTH         = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CW       = sync_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [DEPTH-1:0] s;
    logic             ss;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             level_nxt;

    assign ss = s[DEPTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s     <= {DEPTH{RESET_VALUE}};
            cnt   <= '0;
            level <= RESET_VALUE;
        end else begin
            s     <= {s[DEPTH-2:0], raw};
            cnt   <= cnt_nxt;
            level <= level_nxt;
        end
    end

    // Any return of ss to the current level discards the partial count.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = cnt;
        if (ss == level) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            level_nxt = ss;
            cnt_nxt   = '0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

`ifdef SYNC_EDGE_DETECT_EN
    logic accept;
    logic rise_q;
    logic fall_q;

    assign accept = (ss != level) && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept &  ss;
            fall_q <= accept & ~ss;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer + debounce filter with optional edge pulses.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : in / out / rise / fall / changed, WIDTH channels
// Optional feature macro: SYNC_EDGE_DETECT_EN (rise/fall/changed registers).
// The bus interface must be instantiated with the same WIDTH as this module.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               DEPTH         = 2,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic           clock,
    input  logic           reset_n,
    sync_debounce_if.slave bus
);

    if (!sync_params_ok(DEPTH, STABLE_CYCLES)) begin : g_param_check
        $error("sync_debounce: DEPTH must be 2..8 and STABLE_CYCLES 1..65535");
    end

    logic [WIDTH-1:0] out_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_debounce_channel #(
            .DEPTH         (DEPTH),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VALUE   (RESET_VALUE[i])
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .raw     (bus.in[i]),
            .level   (out_w[i]),
            .rise    (rise_w[i]),
            .fall    (fall_w[i])
        );
    end

    assign bus.out  = out_w;
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;

`ifdef SYNC_EDGE_DETECT_EN
    logic changed_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |(rise_w | fall_w);
        end
    end

    assign bus.changed = changed_q;
`else
    assign bus.changed = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce. Four instances cover the clean step,
// glitch rejection, independent channels, reset mid-count and the
// DEPTH=8 / STABLE_CYCLES=65535 boundary. Edge-pulse expectations follow
// whether SYNC_EDGE_DETECT_EN is defined for the build.
module tb_sync_debounce;

`ifdef SYNC_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic rst_n;
    logic rst_c;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    sync_debounce_if #(.WIDTH(1)) bus_a ();
    sync_debounce_if #(.WIDTH(4)) bus_b ();
    sync_debounce_if #(.WIDTH(1)) bus_c ();
    sync_debounce_if #(.WIDTH(1)) bus_d ();

    sync_debounce #(.WIDTH(1), .DEPTH(2), .STABLE_CYCLES(4), .RESET_VALUE(1'b0))
        u_a (.clock(clock), .reset_n(rst_n), .bus(bus_a.slave));
    sync_debounce #(.WIDTH(4), .DEPTH(2), .STABLE_CYCLES(1), .RESET_VALUE(4'b0000))
        u_b (.clock(clock), .reset_n(rst_n), .bus(bus_b.slave));
    sync_debounce #(.WIDTH(1), .DEPTH(2), .STABLE_CYCLES(8), .RESET_VALUE(1'b1))
        u_c (.clock(clock), .reset_n(rst_c), .bus(bus_c.slave));
    sync_debounce #(.WIDTH(1), .DEPTH(8), .STABLE_CYCLES(65535), .RESET_VALUE(1'b0))
        u_d (.clock(clock), .reset_n(rst_n), .bus(bus_d.slave));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rst_c = 1'b0;
        bus_a.in = 1'b0;
        bus_b.in = 4'b0000;
        bus_c.in = 1'b1;
        bus_d.in = 1'b0;
        #12;
        n_cmp++; if (bus_a.out !== 1'b0) begin n_bad++; $display("FAIL reset_a_out got %b want 0", bus_a.out); end
        n_cmp++; if (bus_a.rise !== 1'b0) begin n_bad++; $display("FAIL reset_a_rise got %b want 0", bus_a.rise); end
        n_cmp++; if (bus_a.changed !== 1'b0) begin n_bad++; $display("FAIL reset_a_changed got %b want 0", bus_a.changed); end
        n_cmp++; if (bus_b.fall !== 4'b0000) begin n_bad++; $display("FAIL reset_b_fall got %b want 0000", bus_b.fall); end
        n_cmp++; if (bus_c.out !== 1'b1) begin n_bad++; $display("FAIL reset_c_out got %b want 1", bus_c.out); end
        @(negedge clock);
        rst_n = 1'b1;
        rst_c = 1'b1;
        repeat (4) begin
            tick();
            n_cmp++; if (bus_a.out !== 1'b0 || bus_a.rise !== 1'b0) begin
                n_bad++; $display("FAIL release_a got out=%b rise=%b want 0/0", bus_a.out, bus_a.rise);
            end
        end
    endtask

    // High for 3 clocks is one short of STABLE_CYCLES=4 and must vanish.
    task automatic test_glitch();
        bus_a.in = 1'b1;
        repeat (3) tick();
        bus_a.in = 1'b0;
        for (int e = 4; e <= 14; e++) begin
            tick();
            n_cmp++; if (bus_a.out !== 1'b0 || bus_a.rise !== 1'b0 || bus_a.changed !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch edge %0d got out=%b rise=%b chg=%b want 0/0/0",
                         e, bus_a.out, bus_a.rise, bus_a.changed);
            end
        end
    endtask

    // Capture edge is edge 1; out/rise/fall at edge 6; changed at edge 7.
    task automatic test_step(input logic lvl);
        logic exp_out, exp_rise, exp_fall, exp_chg;
        bus_a.in = lvl;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_out  = (e >= 6) ? lvl : ~lvl;
            exp_rise = EDGE_EN && lvl && (e == 6);
            exp_fall = EDGE_EN && !lvl && (e == 6);
            exp_chg  = EDGE_EN && (e == 7);
            n_cmp++; if (bus_a.out !== exp_out) begin n_bad++; $display("FAIL step%0b_out edge %0d got %b want %b", lvl, e, bus_a.out, exp_out); end
            n_cmp++; if (bus_a.rise !== exp_rise) begin n_bad++; $display("FAIL step%0b_rise edge %0d got %b want %b", lvl, e, bus_a.rise, exp_rise); end
            n_cmp++; if (bus_a.fall !== exp_fall) begin n_bad++; $display("FAIL step%0b_fall edge %0d got %b want %b", lvl, e, bus_a.fall, exp_fall); end
            n_cmp++; if (bus_a.changed !== exp_chg) begin n_bad++; $display("FAIL step%0b_changed edge %0d got %b want %b", lvl, e, bus_a.changed, exp_chg); end
        end
    endtask

    // STABLE_CYCLES=1, DEPTH=2: new value on out at edge 3 after capture.
    task automatic test_channels();
        logic [3:0] prev, nxt, exp_out, exp_rise, exp_fall;
        logic       exp_chg;
        logic [3:0] pats [2];
        pats[0] = 4'b0101;
        pats[1] = 4'b1010;
        prev = 4'b0000;
        for (int p = 0; p < 2; p++) begin
            nxt = pats[p];
            bus_b.in = nxt;
            for (int e = 1; e <= 5; e++) begin
                tick();
                exp_out  = (e >= 3) ? nxt : prev;
                exp_rise = (EDGE_EN && e == 3) ? (nxt & ~prev) : 4'b0000;
                exp_fall = (EDGE_EN && e == 3) ? (~nxt & prev) : 4'b0000;
                exp_chg  = EDGE_EN && (e == 4);
                n_cmp++; if (bus_b.out !== exp_out) begin n_bad++; $display("FAIL chan_out pat %0d edge %0d got %b want %b", p, e, bus_b.out, exp_out); end
                n_cmp++; if (bus_b.rise !== exp_rise) begin n_bad++; $display("FAIL chan_rise pat %0d edge %0d got %b want %b", p, e, bus_b.rise, exp_rise); end
                n_cmp++; if (bus_b.fall !== exp_fall) begin n_bad++; $display("FAIL chan_fall pat %0d edge %0d got %b want %b", p, e, bus_b.fall, exp_fall); end
                n_cmp++; if (bus_b.changed !== exp_chg) begin n_bad++; $display("FAIL chan_changed pat %0d edge %0d got %b want %b", p, e, bus_b.changed, exp_chg); end
            end
            prev = nxt;
        end
    endtask

    task automatic test_reset_mid_count();
        // Phase 1: count 5 cycles, reset, release with in=1 -> no edges.
        bus_c.in = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_cmp++; if (bus_c.out !== 1'b1) begin n_bad++; $display("FAIL midcnt_pre edge %0d got %b want 1", e, bus_c.out); end
        end
        rst_c = 1'b0;
        #1;
        n_cmp++; if (bus_c.out !== 1'b1 || bus_c.fall !== 1'b0 || bus_c.changed !== 1'b0) begin
            n_bad++; $display("FAIL midcnt_in_reset got out=%b fall=%b chg=%b want 1/0/0", bus_c.out, bus_c.fall, bus_c.changed);
        end
        bus_c.in = 1'b1;
        tick();
        @(negedge clock);
        rst_c = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            n_cmp++; if (bus_c.out !== 1'b1 || bus_c.rise !== 1'b0 || bus_c.fall !== 1'b0 || bus_c.changed !== 1'b0) begin
                n_bad++; $display("FAIL midcnt_post edge %0d got out=%b rise=%b fall=%b chg=%b want 1/0/0/0",
                                  e, bus_c.out, bus_c.rise, bus_c.fall, bus_c.changed);
            end
        end
        // Phase 2: reset mid-count, release with in=0; counter must restart
        // from 0 so out falls at edge 1+DEPTH+STABLE-1 = 10 after release.
        bus_c.in = 1'b0;
        repeat (7) tick();
        rst_c = 1'b0;
        tick();
        @(negedge clock);
        rst_c = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 9) begin
                n_cmp++; if (bus_c.out !== 1'b1) begin n_bad++; $display("FAIL midcnt_restart edge 9 got %b want 1", bus_c.out); end
            end
            if (e == 10) begin
                n_cmp++; if (bus_c.out !== 1'b0) begin n_bad++; $display("FAIL midcnt_restart edge 10 got %b want 0", bus_c.out); end
                n_cmp++; if (bus_c.fall !== EDGE_EN) begin n_bad++; $display("FAIL midcnt_fall edge 10 got %b want %b", bus_c.fall, EDGE_EN); end
            end
        end
    endtask

    // DEPTH=8, STABLE_CYCLES=65535: out must first go high at edge 65543.
    task automatic test_boundary();
        int   first;
        logic rise_at;
        first   = 0;
        rise_at = 1'b0;
        bus_d.in = 1'b1;
        for (int e = 1; e <= 65560; e++) begin
            tick();
            if (first == 0 && bus_d.out === 1'b1) begin
                first   = e;
                rise_at = bus_d.rise;
            end
        end
        n_cmp++; if (first != 65543) begin n_bad++; $display("FAIL boundary_latency got %0d want 65543", first); end
        n_cmp++; if (rise_at !== EDGE_EN) begin n_bad++; $display("FAIL boundary_rise got %b want %b", rise_at, EDGE_EN); end
        n_cmp++; if (bus_d.out !== 1'b1) begin n_bad++; $display("FAIL boundary_hold got %b want 1", bus_d.out); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_step(1'b1);
        test_step(1'b0);
        test_channels();
        test_reset_mid_count();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
